// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters, with a tag pipeline that routes results back.
// Optional ALU_ARB_PRIO0_EN: requester 0 gets fixed absolute priority over the round-robin.
module alu_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_y,
  output logic                    rsp_co,
  output logic [DATA_W-1:0]       alu_a_out,
  output logic [DATA_W-1:0]       alu_b_out,
  output logic [OP_W-1:0]         alu_op_out,
  input  logic [DATA_W-1:0]       alu_y_in,
  input  logic                    alu_co_in
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  // Stage 0 lines up with the registered ALU inputs; the remaining ALU_LAT stages track the ALU itself.
  localparam int unsigned TAG_D = ALU_LAT + 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [TAG_D-1:0]  r_tag_v;
  logic [PTR_W-1:0]  r_tag_id [TAG_D];
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_y;
  logic              r_rsp_co;

  logic              w_prio0;
  logic              w_gnt_any;
  logic              w_ptr_upd;
  logic [PTR_W-1:0]  w_gnt_id;
  logic [N_REQ-1:0]  w_gnt_oh;

  // (base + off) mod N_REQ, valid for base < N_REQ and off < N_REQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int unsigned off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(N_REQ)) s = s - (PTR_W+1)'(N_REQ);
    return s[PTR_W-1:0];
  endfunction

`ifdef ALU_ARB_PRIO0_EN
  assign w_prio0 = req_valid[0];
`else
  assign w_prio0 = 1'b0;
`endif

  // First valid requester in round-robin order starting at r_ptr.
  always_comb begin
    w_gnt_any = 1'b0;
    w_ptr_upd = 1'b0;
    w_gnt_id  = '0;
    if (w_prio0) begin
      w_gnt_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!w_gnt_any && req_valid[rr_idx(r_ptr, k)]) begin
          w_gnt_any = 1'b1;
          w_ptr_upd = 1'b1;
          w_gnt_id  = rr_idx(r_ptr, k);
        end
      end
    end
  end

  assign w_gnt_oh  = w_gnt_any ? (N_REQ'(1) << w_gnt_id) : '0;
  assign req_ready = reset ? w_gnt_oh : '0;

  // Issue side: pointer, ALU operand registers and the tag shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_tag_v  <= '0;
      for (int unsigned k = 0; k < TAG_D; k++) r_tag_id[k] <= '0;
    end else begin
      if (w_gnt_any) begin
        if (w_ptr_upd) r_ptr <= rr_idx(w_gnt_id, 1);
        r_alu_a  <= req_a[w_gnt_id*DATA_W +: DATA_W];
        r_alu_b  <= req_b[w_gnt_id*DATA_W +: DATA_W];
        r_alu_op <= req_op[w_gnt_id*OP_W +: OP_W];
      end
      r_tag_v     <= {r_tag_v[TAG_D-2:0], w_gnt_any};
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned k = 1; k < TAG_D; k++) r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  // Response side: capture the ALU result as its tag leaves the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
      r_rsp_co    <= 1'b0;
    end else begin
      r_rsp_valid <= r_tag_v[TAG_D-1] ? (N_REQ'(1) << r_tag_id[TAG_D-1]) : '0;
      if (r_tag_v[TAG_D-1]) begin
        r_rsp_y  <= alu_y_in;
        r_rsp_co <= alu_co_in;
      end
    end
  end

  assign alu_a_out  = r_alu_a;
  assign alu_b_out  = r_alu_b;
  assign alu_op_out = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_y      = r_rsp_y;
  assign rsp_co     = r_rsp_co;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (ALU_LAT 1 and 3) share stimulus, each with a behavioural ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;

  logic [3:0] rdy1, rv1, rdy3, rv3;
  logic [7:0] y1, y3, a1, b1, a3, b3, ay1, ay3;
  logic       co1, co3, aco1, aco3;
  logic [2:0] op1, op3;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.N_REQ(4), .DATA_W(8), .OP_W(3), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rv1), .rsp_y(y1), .rsp_co(co1),
    .alu_a_out(a1), .alu_b_out(b1), .alu_op_out(op1),
    .alu_y_in(ay1), .alu_co_in(aco1));

  alu_arbiter #(.N_REQ(4), .DATA_W(8), .OP_W(3), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rv3), .rsp_y(y3), .rsp_co(co3),
    .alu_a_out(a3), .alu_b_out(b3), .alu_op_out(op3),
    .alu_y_in(ay3), .alu_co_in(aco3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode 0 is ADD with carry out.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  logic [8:0] m1_q;
  logic [8:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= alu_f(a1, b1, op1);
    m3_q[0] <= alu_f(a3, b3, op3);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign ay1  = m1_q[7:0];
  assign aco1 = m1_q[8];
  assign ay3  = m3_q[2][7:0];
  assign aco3 = m3_q[2][8];

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h40 + i), 8'(8'h07 + i), 3'd0);
    repeat (2) cyc();
    #1;
    n_checks++; if (rdy1 !== 4'h0) begin n_errors++; $display("FAIL reset_ready1 got %h exp 0", rdy1); end
    n_checks++; if (rdy3 !== 4'h0) begin n_errors++; $display("FAIL reset_ready3 got %h exp 0", rdy3); end
    n_checks++; if (rv1 !== 4'h0) begin n_errors++; $display("FAIL reset_rsp_valid1 got %h exp 0", rv1); end
    n_checks++; if (rv3 !== 4'h0) begin n_errors++; $display("FAIL reset_rsp_valid3 got %h exp 0", rv3); end
    n_checks++; if ({y1, co1} !== 9'h0) begin n_errors++; $display("FAIL reset_rsp_y_co got %h exp 0", {y1, co1}); end
    n_checks++; if ({a1, b1, op1} !== 19'h0) begin n_errors++; $display("FAIL reset_alu_in got %h exp 0", {a1, b1, op1}); end
    cyc();
    req_valid = 4'h0;
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
`ifdef ALU_ARB_PRIO0_EN
    int order[5] = '{0, 0, 0, 0, 0};
`else
    int order[5] = '{0, 1, 2, 3, 0};
`endif
    logic [3:0] e;
    for (int i = 0; i < 4; i++) set_req(i, 8'(i*16 + 1), 8'(i + 2), 3'd0);
    for (int c = 0; c < 12; c++) begin
      cyc();
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      e = (c < 5) ? oh(order[c]) : 4'h0;
      n_checks++; if (rdy1 !== e) begin n_errors++; $display("FAIL rr_ready1 c=%0d got %h exp %h", c, rdy1, e); end
      n_checks++; if (rdy3 !== e) begin n_errors++; $display("FAIL rr_ready3 c=%0d got %h exp %h", c, rdy3, e); end
      e = (c >= 3 && c < 8) ? oh(order[c-3]) : 4'h0;
      n_checks++; if (rv1 !== e) begin n_errors++; $display("FAIL rr_rsp_valid1 c=%0d got %h exp %h", c, rv1, e); end
      if (c >= 3 && c < 8) begin
        n_checks++;
        if (y1 !== 8'(order[c-3]*17 + 3)) begin
          n_errors++; $display("FAIL rr_rsp_y1 c=%0d got %h exp %h", c, y1, 8'(order[c-3]*17 + 3));
        end
      end
      e = (c >= 5 && c < 10) ? oh(order[c-5]) : 4'h0;
      n_checks++; if (rv3 !== e) begin n_errors++; $display("FAIL rr_rsp_valid3 c=%0d got %h exp %h", c, rv3, e); end
      if (c >= 5 && c < 10) begin
        n_checks++;
        if (y3 !== 8'(order[c-5]*17 + 3)) begin
          n_errors++; $display("FAIL rr_rsp_y3 c=%0d got %h exp %h", c, y3, 8'(order[c-5]*17 + 3));
        end
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    set_req(2, 8'h05, 8'h03, 3'd0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      if (c > 0) set_req(2, 8'hAA, 8'h55, 3'd4);
      #1;
      e = (c == 0) ? 4'b0100 : 4'b0000;
      n_checks++; if (rdy1 !== e) begin n_errors++; $display("FAIL single_ready c=%0d got %h exp %h", c, rdy1, e); end
      if (c == 1) begin
        n_checks++;
        if ({a1, b1, op1} !== {8'h05, 8'h03, 3'd0}) begin
          n_errors++; $display("FAIL single_alu_in got %h exp %h", {a1, b1, op1}, {8'h05, 8'h03, 3'd0});
        end
      end
      e = (c == 3) ? 4'b0100 : 4'b0000;
      n_checks++; if (rv1 !== e) begin n_errors++; $display("FAIL single_rsp_valid1 c=%0d got %h exp %h", c, rv1, e); end
      if (c == 3) begin
        n_checks++; if ({co1, y1} !== 9'h008) begin n_errors++; $display("FAIL single_rsp1 got %h exp 008", {co1, y1}); end
      end
      e = (c == 5) ? 4'b0100 : 4'b0000;
      n_checks++; if (rv3 !== e) begin n_errors++; $display("FAIL single_rsp_valid3 c=%0d got %h exp %h", c, rv3, e); end
      if (c == 5) begin
        n_checks++; if ({co3, y3} !== 9'h008) begin n_errors++; $display("FAIL single_rsp3 got %h exp 008", {co3, y3}); end
      end
    end
  endtask

  task automatic test_wrap_carry();
    logic [3:0] e;
    set_req(3, 8'hFF, 8'h01, 3'd0);
    set_req(0, 8'h10, 8'h20, 3'd0);
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_valid = (c == 0) ? 4'b1000 : (c == 1) ? 4'b1111 : 4'b0000;
      #1;
      e = (c == 0) ? 4'b1000 : (c == 1) ? 4'b0001 : 4'b0000;
      n_checks++; if (rdy1 !== e) begin n_errors++; $display("FAIL wrap_ready c=%0d got %h exp %h", c, rdy1, e); end
      e = (c == 3) ? 4'b1000 : (c == 4) ? 4'b0001 : 4'b0000;
      n_checks++; if (rv1 !== e) begin n_errors++; $display("FAIL wrap_rsp_valid1 c=%0d got %h exp %h", c, rv1, e); end
      if (c == 3) begin
        n_checks++; if ({co1, y1} !== 9'h100) begin n_errors++; $display("FAIL wrap_carry1 got %h exp 100", {co1, y1}); end
      end
      if (c == 4) begin
        n_checks++; if ({co1, y1} !== 9'h030) begin n_errors++; $display("FAIL wrap_next1 got %h exp 030", {co1, y1}); end
      end
      e = (c == 5) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'b0000;
      n_checks++; if (rv3 !== e) begin n_errors++; $display("FAIL wrap_rsp_valid3 c=%0d got %h exp %h", c, rv3, e); end
      if (c == 5) begin
        n_checks++; if ({co3, y3} !== 9'h100) begin n_errors++; $display("FAIL wrap_carry3 got %h exp 100", {co3, y3}); end
      end
    end
  endtask

  task automatic test_reset_midflight();
`ifdef ALU_ARB_PRIO0_EN
    logic [3:0] g0 = 4'b0001, g1 = 4'b0001;
`else
    logic [3:0] g0 = 4'b0010, g1 = 4'b0100;
`endif
    logic [3:0] e;
    cyc(); req_valid = 4'hF; #1;
    n_checks++; if (rdy1 !== g0) begin n_errors++; $display("FAIL mid_grant0 got %h exp %h", rdy1, g0); end
    cyc(); #1;
    n_checks++; if (rdy1 !== g1) begin n_errors++; $display("FAIL mid_grant1 got %h exp %h", rdy1, g1); end
    cyc(); reset = 1'b0; #1;
    n_checks++; if ({rdy1, rdy3} !== 8'h0) begin n_errors++; $display("FAIL mid_ready_in_reset got %h exp 0", {rdy1, rdy3}); end
    n_checks++; if ({rv1, rv3} !== 8'h0) begin n_errors++; $display("FAIL mid_rsp_valid_in_reset got %h exp 0", {rv1, rv3}); end
    n_checks++; if ({y1, co1, a1, b1, op1} !== 28'h0) begin
      n_errors++; $display("FAIL mid_outputs_in_reset got %h exp 0", {y1, co1, a1, b1, op1});
    end
    for (int c = 3; c < 11; c++) begin
      cyc();
      reset = 1'b1;
      req_valid = (c == 4) ? 4'b1010 : 4'b0000;
      #1;
      if (c == 4) begin
        n_checks++; if (rdy1 !== 4'b0010) begin n_errors++; $display("FAIL mid_first_grant got %h exp 2", rdy1); end
      end
      e = (c == 7) ? 4'b0010 : 4'b0000;
      n_checks++; if (rv1 !== e) begin n_errors++; $display("FAIL mid_rsp_valid1 c=%0d got %h exp %h", c, rv1, e); end
      e = (c == 9) ? 4'b0010 : 4'b0000;
      n_checks++; if (rv3 !== e) begin n_errors++; $display("FAIL mid_rsp_valid3 c=%0d got %h exp %h", c, rv3, e); end
    end
  endtask

`ifdef ALU_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [3:0] e;
    for (int c = 0; c < 10; c++) begin
      cyc();
      req_valid = (c < 4) ? 4'b0011 : (c == 4) ? 4'b0010 : 4'b0000;
      #1;
      e = (c < 4) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      n_checks++; if (rdy1 !== e) begin n_errors++; $display("FAIL prio_ready c=%0d got %h exp %h", c, rdy1, e); end
      e = (c >= 3 && c < 7) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000;
      n_checks++; if (rv1 !== e) begin n_errors++; $display("FAIL prio_rsp_valid1 c=%0d got %h exp %h", c, rv1, e); end
    end
  endtask
`endif

  initial begin
    req_valid = 4'h0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap_carry();
    test_reset_midflight();
`ifdef ALU_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
